// File: rtl/sha2_kconst_sequencer.sv
// SHA-2 round-constant streamer: K[0..ROUNDS-1] over valid/ready.
// WORD_W=32 serves SHA-224/256, WORD_W=64 serves SHA-384/512.
module sha2_kconst_sequencer #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              k_valid,
  input  logic              k_ready,
  output logic [WORD_W-1:0] k_data,
  output logic [6:0]        k_round,
  output logic              k_last,
  output logic              busy,
  output logic              done
);

  localparam int ROUNDS = (WORD_W == 64) ? 80 : 64;
  localparam logic [6:0] LAST = 7'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;

  // SHA-512 constants; SHA-256 K is the upper half of entries 0..63
  function automatic logic [63:0] k_rom(input logic [6:0] idx);
    logic [63:0] k;
    case (idx)
      7'd0:  k = 64'h428a2f98d728ae22;
      7'd1:  k = 64'h7137449123ef65cd;
      7'd2:  k = 64'hb5c0fbcfec4d3b2f;
      7'd3:  k = 64'he9b5dba58189dbbc;
      7'd4:  k = 64'h3956c25bf348b538;
      7'd5:  k = 64'h59f111f1b605d019;
      7'd6:  k = 64'h923f82a4af194f9b;
      7'd7:  k = 64'hab1c5ed5da6d8118;
      7'd8:  k = 64'hd807aa98a3030242;
      7'd9:  k = 64'h12835b0145706fbe;
      7'd10: k = 64'h243185be4ee4b28c;
      7'd11: k = 64'h550c7dc3d5ffb4e2;
      7'd12: k = 64'h72be5d74f27b896f;
      7'd13: k = 64'h80deb1fe3b1696b1;
      7'd14: k = 64'h9bdc06a725c71235;
      7'd15: k = 64'hc19bf174cf692694;
      7'd16: k = 64'he49b69c19ef14ad2;
      7'd17: k = 64'hefbe4786384f25e3;
      7'd18: k = 64'h0fc19dc68b8cd5b5;
      7'd19: k = 64'h240ca1cc77ac9c65;
      7'd20: k = 64'h2de92c6f592b0275;
      7'd21: k = 64'h4a7484aa6ea6e483;
      7'd22: k = 64'h5cb0a9dcbd41fbd4;
      7'd23: k = 64'h76f988da831153b5;
      7'd24: k = 64'h983e5152ee66dfab;
      7'd25: k = 64'ha831c66d2db43210;
      7'd26: k = 64'hb00327c898fb213f;
      7'd27: k = 64'hbf597fc7beef0ee4;
      7'd28: k = 64'hc6e00bf33da88fc2;
      7'd29: k = 64'hd5a79147930aa725;
      7'd30: k = 64'h06ca6351e003826f;
      7'd31: k = 64'h142929670a0e6e70;
      7'd32: k = 64'h27b70a8546d22ffc;
      7'd33: k = 64'h2e1b21385c26c926;
      7'd34: k = 64'h4d2c6dfc5ac42aed;
      7'd35: k = 64'h53380d139d95b3df;
      7'd36: k = 64'h650a73548baf63de;
      7'd37: k = 64'h766a0abb3c77b2a8;
      7'd38: k = 64'h81c2c92e47edaee6;
      7'd39: k = 64'h92722c851482353b;
      7'd40: k = 64'ha2bfe8a14cf10364;
      7'd41: k = 64'ha81a664bbc423001;
      7'd42: k = 64'hc24b8b70d0f89791;
      7'd43: k = 64'hc76c51a30654be30;
      7'd44: k = 64'hd192e819d6ef5218;
      7'd45: k = 64'hd69906245565a910;
      7'd46: k = 64'hf40e35855771202a;
      7'd47: k = 64'h106aa07032bbd1b8;
      7'd48: k = 64'h19a4c116b8d2d0c8;
      7'd49: k = 64'h1e376c085141ab53;
      7'd50: k = 64'h2748774cdf8eeb99;
      7'd51: k = 64'h34b0bcb5e19b48a8;
      7'd52: k = 64'h391c0cb3c5c95a63;
      7'd53: k = 64'h4ed8aa4ae3418acb;
      7'd54: k = 64'h5b9cca4f7763e373;
      7'd55: k = 64'h682e6ff3d6b2b8a3;
      7'd56: k = 64'h748f82ee5defb2fc;
      7'd57: k = 64'h78a5636f43172f60;
      7'd58: k = 64'h84c87814a1f0ab72;
      7'd59: k = 64'h8cc702081a6439ec;
      7'd60: k = 64'h90befffa23631e28;
      7'd61: k = 64'ha4506cebde82bde9;
      7'd62: k = 64'hbef9a3f7b2c67915;
      7'd63: k = 64'hc67178f2e372532b;
      7'd64: k = 64'hca273eceea26619c;
      7'd65: k = 64'hd186b8c721c0c207;
      7'd66: k = 64'heada7dd6cde0eb1e;
      7'd67: k = 64'hf57d4f7fee6ed178;
      7'd68: k = 64'h06f067aa72176fba;
      7'd69: k = 64'h0a637dc5a2c898a6;
      7'd70: k = 64'h113f9804bef90dae;
      7'd71: k = 64'h1b710b35131c471b;
      7'd72: k = 64'h28db77f523047d84;
      7'd73: k = 64'h32caab7b40c72493;
      7'd74: k = 64'h3c9ebe0a15c9bebc;
      7'd75: k = 64'h431d67c49c100d4c;
      7'd76: k = 64'h4cc5d4becb3e42b6;
      7'd77: k = 64'h597f299cfc657e2a;
      7'd78: k = 64'h5fcb6fab3ad6faec;
      7'd79: k = 64'h6c44198c4a475817;
      default: k = 64'h0;
    endcase
    return k;
  endfunction

  // upper WORD_W bits of the 64-bit entry
  function automatic logic [WORD_W-1:0] k_word(input logic [6:0] idx);
    return WORD_W'(k_rom(idx) >> (64 - WORD_W));
  endfunction

  logic [6:0] next_round;
  assign next_round = k_round + 7'd1;

  // sequencer FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      k_valid <= 1'b0;
      k_data  <= '0;
      k_round <= '0;
      k_last  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state   <= RUN;
            k_data  <= k_word(7'd0);
            k_round <= 7'd0;
            k_valid <= 1'b1;
            k_last  <= (LAST == 7'd0);
            busy    <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state   <= IDLE;
            k_valid <= 1'b0;
            k_round <= 7'd0;
            k_last  <= 1'b0;
            busy    <= 1'b0;
          end else if (k_valid && k_ready) begin
            if (k_last) begin
              state   <= DONE;
              k_valid <= 1'b0;
              k_last  <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              k_round <= next_round;
              k_data  <= k_word(next_round);
              k_last  <= (next_round == LAST);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          k_valid <= 1'b0;
          k_last  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha2_kconst_sequencer.sv
// Bench for sha2_kconst_sequencer: 32- and 64-bit instances side by side,
// checked every cycle against a transaction-level reference model.
module tb_sha2_kconst_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic k_ready = 1'b0;

  logic        v32, l32, b32, dn32;
  logic [31:0] d32;
  logic [6:0]  r32;
  logic        v64, l64, b64, dn64;
  logic [63:0] d64;
  logic [6:0]  r64;

  always #5 clk = ~clk;

  sha2_kconst_sequencer #(.WORD_W(32)) dut32 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .k_valid(v32), .k_ready(k_ready), .k_data(d32),
    .k_round(r32), .k_last(l32), .busy(b32), .done(dn32)
  );

  sha2_kconst_sequencer #(.WORD_W(64)) dut64 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .k_valid(v64), .k_ready(k_ready), .k_data(d64),
    .k_round(r64), .k_last(l64), .busy(b64), .done(dn64)
  );

  // FIPS 180-4 SHA-512 round constants
  logic [63:0] kt [0:79] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  int vectors = 0;
  int errors = 0;

  // reference model per instance: streaming?, current round, done pulse,
  // and whether k_round has a defined value to compare against
  int rounds [2] = '{64, 80};
  bit m_stream [2];
  int m_round [2];
  bit m_done [2];
  bit m_rchk [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] get(input int d, input int f);
    logic [63:0] r;
    r = '0;
    case (f)
      0: r = 64'(d == 0 ? v32 : v64);
      1: r = 64'(d == 0 ? b32 : b64);
      2: r = 64'(d == 0 ? dn32 : dn64);
      3: r = 64'(d == 0 ? l32 : l64);
      4: r = 64'(d == 0 ? r32 : r64);
      default: r = (d == 0) ? 64'(d32) : d64;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] expk(input int d, input int r);
    logic [63:0] e;
    e = kt[r];
    return (d == 0) ? {32'h0, e[63:32]} : e;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_stream[d] = 0;
      m_round[d] = 0;
      m_done[d] = 0;
      m_rchk[d] = 1;
    end
  endtask

  // advance the model by one clock using the inputs about to be sampled
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      bit nd;
      nd = 0;
      if (m_stream[d]) begin
        if (abort) begin
          m_stream[d] = 0;
          m_round[d] = 0;
          m_rchk[d] = 1;
        end else if (k_ready) begin
          if (m_round[d] == rounds[d] - 1) begin
            m_stream[d] = 0;
            m_rchk[d] = 0;
            nd = 1;
          end else begin
            m_round[d]++;
          end
        end
      end else if (!m_done[d] && start && !abort) begin
        m_stream[d] = 1;
        m_round[d] = 0;
        m_rchk[d] = 1;
      end
      m_done[d] = nd;
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 2; d++) begin
      string w;
      w = $sformatf("%s.w%0d", tag, d == 0 ? 32 : 64);
      chk({w, ".valid"}, get(d, 0), 64'(m_stream[d]));
      chk({w, ".busy"}, get(d, 1), 64'(m_stream[d]));
      chk({w, ".done"}, get(d, 2), 64'(m_done[d]));
      chk({w, ".last"}, get(d, 3),
          64'(m_stream[d] && m_round[d] == rounds[d] - 1));
      if (m_rchk[d])
        chk({w, ".round"}, get(d, 4), 64'(m_round[d]));
      if (m_stream[d])
        chk({w, ".data"}, get(d, 5), expk(d, m_round[d]));
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic run_to_round(input int n, input string tag);
    int i;
    i = 0;
    while (!(v32 && r32 == 7'(n)) && i < 300) begin
      tick(tag);
      i++;
    end
    chk({tag, ".reach"}, v32 ? 64'(r32) : 64'h7f, 64'(n));
  endtask

  task automatic run_idle(input string tag);
    int i;
    i = 0;
    k_ready = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    while ((b32 || b64 || dn32 || dn64) && i < 300) begin
      tick(tag);
      i++;
    end
    tick(tag);
    chk({tag, ".idle"}, 64'({b32, b64, dn32, dn64}), 64'h0);
  endtask

  initial begin
    int n, at32, at64;
    model_reset();
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.data32", 64'(d32), 64'h0);
    chk("reset.data64", d64, 64'h0);
    rst = 1'b0;
    tick("idle");

    // full-rate run of both widths, with start-to-done latency
    k_ready = 1'b1;
    start = 1'b1;
    tick("t1");
    start = 1'b0;
    n = 1;
    at32 = 0;
    at64 = 0;
    for (int i = 0; i < 100; i++) begin
      if (dn32 && at32 == 0) at32 = n;
      if (dn64 && at64 == 0) at64 = n;
      if (at32 != 0 && at64 != 0) break;
      tick("t1");
      n++;
    end
    chk("t1.lat32", 64'(at32), 64'd65);
    chk("t1.lat64", 64'(at64), 64'd81);
    run_idle("t1");

    // back-pressure at round 5
    start = 1'b1;
    tick("t2");
    start = 1'b0;
    run_to_round(5, "t2");
    k_ready = 1'b0;
    repeat (3) tick("t2.stall");
    k_ready = 1'b1;
    tick("t2.resume");
    run_idle("t2");

    // abort mid-run, then replay from K[0]
    start = 1'b1;
    tick("t4");
    start = 1'b0;
    run_to_round(10, "t4");
    abort = 1'b1;
    tick("t4.abort");
    abort = 1'b0;
    tick("t4.after");
    start = 1'b1;
    tick("t4.restart");
    start = 1'b0;
    run_idle("t4");

    // start while busy is ignored; start with abort in idle stays idle
    start = 1'b1;
    tick("t5");
    start = 1'b0;
    run_to_round(20, "t5");
    start = 1'b1;
    tick("t5.busy_start");
    start = 1'b0;
    repeat (2) tick("t5.cont");
    run_idle("t5");
    start = 1'b1;
    abort = 1'b1;
    tick("t5.both");
    start = 1'b0;
    abort = 1'b0;
    tick("t5.both2");

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      k_ready = ($urandom_range(0, 9) < 7);
      start = ($urandom_range(0, 19) == 0);
      abort = ($urandom_range(0, 49) == 0);
      tick("rnd");
    end
    run_idle("rnd");

    // asynchronous reset mid-cycle
    start = 1'b1;
    tick("t6");
    start = 1'b0;
    run_to_round(30, "t6");
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("t6.async");
    chk("t6.data32", 64'(d32), 64'h0);
    chk("t6.data64", d64, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick("t6.idle");
    start = 1'b1;
    tick("t6.restart");
    start = 1'b0;
    run_idle("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
